imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender.
- Takes a 32-bit immediate, an `IMM_SRC` format code and a base instruction word, and produces the instruction word with the immediate scattered into its RISC-V bit positions.
- Checks that the immediate is representable in the chosen format.
- Used by the self-test instruction generator and the patch/trampoline writer.
- Valid/ready streaming block: one registered output stage plus a skid buffer.

Parameters:
- `ERRCNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid & in_ready`.
- `in_imm` input 32: immediate value (already sign-extended / shifted, as the extender outputs it).
- `in_base` input 32: instruction word supplying opcode, rd, rs1, rs2 and funct fields.
- `IMM_SRC` input 3: format code. 000=I, 001=S, 010=B, 011=U, 100=J; others are illegal.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer ready.
- `out_instr` output 32: encoded instruction.
- `out_err` output 1: immediate not representable, or `IMM_SRC` illegal.
- `err_clr` input 1: synchronous clear of `err_cnt`.
- `err_cnt` output `ERRCNT_W`: count of errored results delivered.

Behaviour:
- Field mapping, as bits of `instr[31:7]` (`r[k]` = `instr[k+7]`):
  - I: `r[24:13]` = `imm[11:0]`.
  - S: `r[24:18]` = `imm[11:5]`; `r[4:0]` = `imm[4:0]`.
  - B: `r[24]` = `imm[12]`; `r[23:18]` = `imm[10:5]`; `r[4:1]` = `imm[4:1]`; `r[0]` = `imm[11]`.
  - U: `r[24:5]` = `imm[31:12]`.
  - J: `r[24]` = `imm[20]`; `r[23:14]` = `imm[10:1]`; `r[13]` = `imm[11]`; `r[12:5]` = `imm[19:12]`.
- Merge: bits not covered by the format's mask come from `in_base` unchanged. `instr[6:0]` always comes from base.
- Representability checks (`err`):
  - I/S: `imm[31:11]` all equal.
  - B: `imm[31:12]` all equal and `imm[0]`==0.
  - U: `imm[11:0]`==0.
  - J: `imm[31:20]` all equal and `imm[0]`==0.
  - Illegal `IMM_SRC`: `err`=1 and `out_instr` = `in_base`.
- On error in a legal format, the truncated fields are still written and `out_err`=1.
- Handshake and timing:
  - Latency 1 cycle from input handshake to `out_valid`.
  - Throughput 1/cycle while `out_ready`=1.
  - `out_valid`/`out_instr`/`out_err` are held stable until `out_ready`.
- Skid buffer:
  - `in_ready` = `!skid_valid`, a registered term with no combinational path from `out_ready`.
  - When the output register is full and `out_ready`=0, the accepted input goes to the skid register.
  - When `out_ready` rises, skid moves to the output.
  - Order preserved; no drop, no duplicate.
- Simultaneous output pop and input push with the skid empty: the output register loads the new input directly.
- `err_cnt`:
  - Increments on an output handshake with `out_err`=1.
  - Saturates at all-ones.
  - `err_clr` wins over a same-cycle increment, giving 0.
- Reset (async assert, sync-safe deassert):
  - `out_valid`=0, `out_instr`=0, `out_err`=0, `err_cnt`=0, skid empty, so `in_ready`=1.
  - Reset mid-transfer discards both registers.

Optional Feature:
- Macro `IMM_ENCODER_ERRCNT_EN`.
- Defined: `err_cnt` is implemented as specified.
- Undefined: the counter logic is removed, `err_cnt` is tied to 0 and `err_clr` is ignored. `out_err` is unaffected.

Decomposition:
- Shared package `imm_pkg`:
  - `IMM_I`/`IMM_S`/`IMM_B`/`IMM_U`/`IMM_J` 3-bit codes, shared with the extender.
  - Per-format 32-bit field masks.
- Sub-module `imm_scatter`: pure combinational encode + check (`imm`, `IMM_SRC` -> `raw[24:0]`, `mask`, `err`).
- Top level holds the handshake, skid and counter.

Test Plan:
1. I-type: `imm`=0xFFFFF800 (-2048), `base`=0x00000013 -> `out_instr`=0x80000013, `out_err`=0. Same with `imm`=0x00000800 -> `out_err`=1, `err_cnt`=1.
2. B-type: `imm`=0x00000FFE, `base`=0x00000063 -> `out_instr`=0x7E000FE3 (bits 31:25=0x3F, 11:7=0x1F), `out_err`=0. `imm`=0x00000003 -> `out_err`=1 (odd).
3. J-type: `imm`=0xFFF00000 (min) -> `instr[31]`=1 and bits 30:12 zero. U-type: `imm`=0x12345000 -> `instr[31:12]`=0x12345. U-type: `imm`=0x12345001 -> `out_err`=1.
4. Round trip: 10k random legal (`imm`, `IMM_SRC`) pairs -> feed `out_instr[31:7]` to the extender, result equals `imm`. Non-immediate bits equal base.
5. Backpressure: stream 8 requests with `out_ready` toggling randomly. Expect `in_ready` to drop only when skid is full, order preserved, outputs stable while stalled.
6. Illegal `IMM_SRC`=101 -> `out_instr`=`in_base`, `out_err`=1. Drive 300 errors with `ERRCNT_W`=8 -> `err_cnt`=255. `err_clr` with a concurrent error -> `err_cnt`=0. Assert `rst_n` mid-stall -> all outputs 0, `in_ready`=1.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate extender/encoder pair.
//   imm_src_e   : 3-bit IMM_SRC format codes (I/S/B/U/J); other codes are illegal.
//   MASK_*      : per-format masks of the instruction bits that carry immediate data.
//   fits_above  : true when v[31:msb] are all equal (sign-extension check).
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  function automatic logic fits_above(input logic [31:0] v, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'hFFFF_FFFF << msb;
    return ((v & hi) == hi) || ((v & hi) == '0);
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// imm_scatter: combinational immediate encode + representability check.
//   i_imm     [31:0] : immediate as the extender would produce it
//   i_imm_src [2:0]  : format code (imm_src_e)
//   o_raw     [24:0] : immediate scattered into instr[31:7] positions
//   o_mask    [31:0] : instruction bits owned by the format (0 when illegal)
//   o_err            : immediate not representable, or format illegal
module imm_scatter
  import imm_pkg::*;
(
  input  logic [31:0] i_imm,
  input  logic [2:0]  i_imm_src,
  output logic [24:0] o_raw,
  output logic [31:0] o_mask,
  output logic        o_err
);

  imm_src_e w_src;
  assign w_src = imm_src_e'(i_imm_src);

  always_comb begin
    o_raw  = '0;
    o_mask = '0;
    o_err  = 1'b1;
    case (w_src)
      IMM_I: begin
        o_raw  = {i_imm[11:0], 13'b0};
        o_mask = MASK_I;
        o_err  = !fits_above(i_imm, 11);
      end
      IMM_S: begin
        o_raw  = {i_imm[11:5], 13'b0, i_imm[4:0]};
        o_mask = MASK_S;
        o_err  = !fits_above(i_imm, 11);
      end
      IMM_B: begin
        o_raw  = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11]};
        o_mask = MASK_B;
        o_err  = !fits_above(i_imm, 12) || i_imm[0];
      end
      IMM_U: begin
        o_raw  = {i_imm[31:12], 5'b0};
        o_mask = MASK_U;
        o_err  = (i_imm[11:0] != '0);
      end
      IMM_J: begin
        o_raw  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 5'b0};
        o_mask = MASK_J;
        o_err  = !fits_above(i_imm, 20) || i_imm[0];
      end
      default: begin
        o_raw  = '0;
        o_mask = '0;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: streams (imm, IMM_SRC, base) requests into encoded RISC-V
// instruction words, flagging immediates that do not fit the format.
// One registered output stage plus a one-entry skid buffer.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake (in_ready is registered)
//   in_imm, in_base      : immediate and base instruction word
//   IMM_SRC              : format code (I/S/B/U/J, others illegal)
//   out_valid/out_ready  : result handshake
//   out_instr, out_err   : encoded word, representability error
//   err_clr, err_cnt     : clear / saturating count of errored results
// Optional: define IMM_ENCODER_ERRCNT_EN to build the error counter;
// otherwise err_cnt is tied to 0 and err_clr is ignored.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_base,
  input  logic [2:0]          IMM_SRC,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic [24:0] w_raw;
  logic [31:0] w_mask;
  logic        w_err;
  logic [31:0] w_instr;
  logic        w_push;
  logic        w_pop;

  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_err;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic        r_skid_err;

  imm_scatter u_scatter (
    .i_imm     (in_imm),
    .i_imm_src (IMM_SRC),
    .o_raw     (w_raw),
    .o_mask    (w_mask),
    .o_err     (w_err)
  );

  // Illegal formats give an all-zero mask, so the base passes through untouched.
  assign w_instr = (in_base & ~w_mask) | ({w_raw, 7'b0} & w_mask);

  assign in_ready  = !r_skid_valid;
  assign w_push    = in_valid && !r_skid_valid;
  assign w_pop     = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;

  // Skid only fills while the output is full and stalled; since in_ready is
  // low whenever skid is full, a pop with skid valid never coincides with a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_err   <= 1'b0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_out_instr  <= r_skid_instr;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_push) begin
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (!r_out_valid) begin
      if (w_push) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
      end
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= w_instr;
      r_skid_err   <= w_err;
    end
  end

`ifdef IMM_ENCODER_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_pop && r_out_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_cnt          = '0;
`endif

endmodule
